regfile_sb: RTL and testbench

// Parametrised multi-port integer register file for the core's decode/writeback stages.

---
 rtl/regfile_sb_if.sv | 30 +++
 rtl/regfile_sb.sv | 98 +++++++++
 tb/tb_regfile_sb.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bus bundle for the scoreboarded register file: two writeback ports,
// packed read ports, the reservation request and the busy status.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
);
  logic                we0;
  logic [AW-1:0]       wa0;
  logic [XLEN-1:0]     wd0;
  logic                we1;
  logic [AW-1:0]       wa1;
  logic [XLEN-1:0]     wd1;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic                res_en;
  logic [AW-1:0]       res_addr;
  logic [AW:0]         busy_cnt;

  modport master (
    output we0, wa0, wd0, we1, wa1, wd1, ra, res_en, res_addr,
    input  rd, rbusy, busy_cnt
  );

  modport slave (
    input  we0, wa0, wd0, we1, wa1, wd1, ra, res_en, res_addr,
    output rd, rbusy, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port integer register file with ALU/MEM writeback ports, optional
// write-to-read forwarding and a per-register busy scoreboard for RAW stalls.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NRD      = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  logic [XLEN-1:0]     regs_q [NREG];
  logic [XLEN-1:0]     regs_d [NREG];
  logic [NREG-1:0]     busy_q;
  logic [NREG-1:0]     busy_d;
  logic [NRD*XLEN-1:0] rd_c;
  logic [NRD-1:0]      rbusy_c;
  logic [AW:0]         busy_cnt_c;
  logic [AW-1:0]       ra_i;
  logic [XLEN-1:0]     rd_i;
  logic                busy_i;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Next register contents; port 1 is applied last so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (bus.we0 && !is_zero(bus.wa0)) regs_d[bus.wa0] = bus.wd0;
    if (bus.we1 && !is_zero(bus.wa1)) regs_d[bus.wa1] = bus.wd1;
  end

  // Scoreboard: writebacks retire a reservation, a new reservation in the same cycle re-arms it.
  always_comb begin
    busy_d = busy_q;
    if (bus.we0) busy_d[bus.wa0] = 1'b0;
    if (bus.we1) busy_d[bus.wa1] = 1'b0;
    if (bus.res_en && !is_zero(bus.res_addr)) busy_d[bus.res_addr] = 1'b1;
  end

  // State registers; reset discards stored data and every outstanding reservation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Combinational read ports with optional forwarding; a forwarded value is never reported busy.
  always_comb begin
    rd_c    = '0;
    rbusy_c = '0;
    ra_i    = '0;
    rd_i    = '0;
    busy_i  = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra_i   = bus.ra[i*AW +: AW];
      rd_i   = regs_q[ra_i];
      busy_i = busy_q[ra_i];
      if (BYPASS) begin
        if (bus.we0 && (bus.wa0 == ra_i)) begin
          rd_i   = bus.wd0;
          busy_i = 1'b0;
        end
        if (bus.we1 && (bus.wa1 == ra_i)) begin
          rd_i   = bus.wd1;
          busy_i = 1'b0;
        end
      end
      // Forwarding must not leak through while the array is held in reset.
      if (is_zero(ra_i) || !rst_n) begin
        rd_i   = '0;
        busy_i = 1'b0;
      end
      rd_c[i*XLEN +: XLEN] = rd_i;
      rbusy_c[i]           = busy_i;
    end
  end

  // Population count of the registered busy bits.
  always_comb begin
    busy_cnt_c = '0;
    for (int i = 0; i < NREG; i++) busy_cnt_c = busy_cnt_c + (AW+1)'(busy_q[i]);
  end

  assign bus.rd       = rd_c;
  assign bus.rbusy    = rbusy_c;
  assign bus.busy_cnt = busy_cnt_c;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a 2-port bypassing instance checked every cycle against a
// rule-level model plus literal expectations, and a 4-port 64-bit non-bypassing instance.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .AW(5), .NRD(2)) ifa ();
  regfile_sb_if #(.XLEN(64), .AW(5), .NRD(4)) ifb ();

  regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .NRD(2), .BYPASS(1'b1), .ZERO_REG(1'b1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  regfile_sb #(.XLEN(64), .NREG(32), .AW(5), .NRD(4), .BYPASS(1'b0), .ZERO_REG(1'b1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  logic [31:0] m_reg  [32] = '{default: '0};
  bit          m_busy [32] = '{default: 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model of instance A ----------------
  always @(negedge rst_n) begin
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (ifa.we0 && ifa.wa0 != 0) m_reg[ifa.wa0] = ifa.wd0;
      if (ifa.we1 && ifa.wa1 != 0) m_reg[ifa.wa1] = ifa.wd1;
      if (ifa.we0) m_busy[ifa.wa0] = 1'b0;
      if (ifa.we1) m_busy[ifa.wa1] = 1'b0;
      if (ifa.res_en && ifa.res_addr != 0) m_busy[ifa.res_addr] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (rst_n !== 1'b1 || a == 0) return 32'd0;
    if (ifa.we1 && ifa.wa1 == a) return ifa.wd1;
    if (ifa.we0 && ifa.wa0 == a) return ifa.wd0;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (rst_n !== 1'b1 || a == 0) return 1'b0;
    if ((ifa.we0 && ifa.wa0 == a) || (ifa.we1 && ifa.wa1 == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("model rd%0d", p), 64'(ifa.rd[p*32 +: 32]), 64'(exp_rd(ifa.ra[p*5 +: 5])));
        check($sformatf("model rbusy%0d", p), 64'(ifa.rbusy[p]), 64'(exp_busy(ifa.ra[p*5 +: 5])));
      end
      check("model busy_cnt", 64'(ifa.busy_cnt), 64'(exp_cnt()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_a();
    ifa.we0 = 1'b0; ifa.wa0 = '0; ifa.wd0 = '0;
    ifa.we1 = 1'b0; ifa.wa1 = '0; ifa.wd1 = '0;
    ifa.ra = '0; ifa.res_en = 1'b0; ifa.res_addr = '0;
  endtask

  task automatic idle_b();
    ifb.we0 = 1'b0; ifb.wa0 = '0; ifb.wd0 = '0;
    ifb.we1 = 1'b0; ifb.wa1 = '0; ifb.wd1 = '0;
    ifb.ra = '0; ifb.res_en = 1'b0; ifb.res_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_a();
    idle_b();
    #2;
    ifa.ra = {5'd3, 5'd5};
    #1;
    check("reset rd", 64'(ifa.rd), 64'd0);
    check("reset busy_cnt", 64'(ifa.busy_cnt), 64'd0);
    #9;
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    // write / read, zero register
    tick(); idle_a();
    ifa.we0 = 1'b1; ifa.wa0 = 5'd5; ifa.wd0 = 32'hDEADBEEF; ifa.ra = {5'd0, 5'd5};
    #1 check("bypass w0", 64'(ifa.rd[31:0]), 64'hDEADBEEF);
    tick(); idle_a();
    ifa.ra = {5'd0, 5'd5}; ifa.we0 = 1'b1; ifa.wa0 = 5'd0; ifa.wd0 = 32'hFFFFFFFF;
    #1 check("stored r5", 64'(ifa.rd[31:0]), 64'hDEADBEEF);
    check("x0 during write", 64'(ifa.rd[63:32]), 64'd0);
    tick(); idle_a();
    #1 check("x0 after write", 64'(ifa.rd[31:0]), 64'd0);

    // bypass, then collision
    tick(); idle_a();
    ifa.we1 = 1'b1; ifa.wa1 = 5'd7; ifa.wd1 = 32'h12345678; ifa.ra = {5'd7, 5'd5};
    #1 check("bypass rd1", 64'(ifa.rd[63:32]), 64'h12345678);
    tick(); idle_a();
    ifa.we0 = 1'b1; ifa.wa0 = 5'd3; ifa.wd0 = 32'd1;
    ifa.we1 = 1'b1; ifa.wa1 = 5'd3; ifa.wd1 = 32'd2; ifa.ra = {5'd3, 5'd7};
    #1 check("collision fwd", 64'(ifa.rd[63:32]), 64'd2);
    check("stored r7", 64'(ifa.rd[31:0]), 64'h12345678);
    tick(); idle_a();
    ifa.ra = {5'd0, 5'd3};
    #1 check("collision stored", 64'(ifa.rd[31:0]), 64'd2);

    // scoreboard set / clear
    tick(); idle_a();
    ifa.res_en = 1'b1; ifa.res_addr = 5'd9; ifa.ra = {5'd0, 5'd9};
    #1 check("rbusy pre reserve", 64'(ifa.rbusy[0]), 64'd0);
    tick(); idle_a();
    ifa.ra = {5'd9, 5'd9};
    #1 check("rbusy r9", 64'(ifa.rbusy), 64'b11);
    check("cnt after reserve", 64'(ifa.busy_cnt), 64'd1);
    tick(); idle_a();
    ifa.we0 = 1'b1; ifa.wa0 = 5'd9; ifa.wd0 = 32'hAA; ifa.ra = {5'd9, 5'd9};
    #1 check("rbusy cleared by fwd", 64'(ifa.rbusy), 64'd0);
    check("cnt not bypassed", 64'(ifa.busy_cnt), 64'd1);
    tick(); idle_a();
    ifa.ra = {5'd0, 5'd9};
    #1 check("cnt after clear", 64'(ifa.busy_cnt), 64'd0);
    check("r9 data", 64'(ifa.rd[31:0]), 64'hAA);

    // reserve beats clear, x0 reserve ignored, WAW
    tick(); idle_a();
    ifa.res_en = 1'b1; ifa.res_addr = 5'd4;
    ifa.we1 = 1'b1; ifa.wa1 = 5'd4; ifa.wd1 = 32'h44; ifa.ra = {5'd4, 5'd4};
    #1 check("r4 fwd", 64'(ifa.rd[31:0]), 64'h44);
    tick(); idle_a();
    ifa.ra = {5'd0, 5'd4};
    #1 check("reserve wins", 64'(ifa.rbusy[0]), 64'd1);
    check("cnt reserve wins", 64'(ifa.busy_cnt), 64'd1);
    tick(); idle_a();
    ifa.res_en = 1'b1; ifa.res_addr = 5'd0;
    tick(); idle_a();
    #1 check("cnt x0 reserve", 64'(ifa.busy_cnt), 64'd1);
    ifa.res_en = 1'b1; ifa.res_addr = 5'd4;
    tick(); idle_a();
    ifa.res_en = 1'b1; ifa.res_addr = 5'd20; ifa.ra = {5'd20, 5'd4};
    #1 check("cnt waw", 64'(ifa.busy_cnt), 64'd1);
    check("rbusy waw", 64'(ifa.rbusy), 64'b01);
    tick(); idle_a();
    ifa.ra = {5'd20, 5'd4};
    #1 check("cnt two busy", 64'(ifa.busy_cnt), 64'd2);
    check("rbusy both", 64'(ifa.rbusy), 64'b11);

    // mixed traffic, checked by the model every cycle
    for (int k = 0; k < 48; k++) begin
      tick(); idle_a();
      ifa.we0 = k[0];
      ifa.wa0 = 5'((k * 7) % 32);
      ifa.wd0 = 32'h1000_0000 + 32'(k);
      ifa.we1 = (k % 3 == 0);
      ifa.wa1 = 5'((k * 5 + 1) % 32);
      ifa.wd1 = 32'hA000_0000 ^ 32'(k);
      ifa.res_en = (k % 4 == 1);
      ifa.res_addr = 5'((k * 11) % 32);
      ifa.ra = {5'((k * 5 + 1) % 32), 5'((k * 3) % 32)};
    end

    // every non-zero register reserved
    for (int k = 1; k < 32; k++) begin
      tick(); idle_a();
      ifa.res_en = 1'b1; ifa.res_addr = 5'(k);
    end
    tick(); idle_a();
    #1 check("cnt all busy", 64'(ifa.busy_cnt), 64'd31);

    // reset in the middle of a write
    tick(); idle_a();
    ifa.we0 = 1'b1; ifa.wa0 = 5'd5; ifa.wd0 = 32'h55; ifa.ra = {5'd4, 5'd5};
    #2 rst_n = 1'b0;
    #1 check("async reset rd", 64'(ifa.rd), 64'd0);
    check("async reset rbusy", 64'(ifa.rbusy), 64'd0);
    check("async reset cnt", 64'(ifa.busy_cnt), 64'd0);
    @(posedge clk);
    #1 check("no write in reset", 64'(ifa.rd[31:0]), 64'd0);
    idle_a();
    ifa.ra = {5'd4, 5'd5};
    #1 rst_n = 1'b1;
    #1 check("r5 lost", 64'(ifa.rd[31:0]), 64'd0);
    check("r4 lost", 64'(ifa.rd[63:32]), 64'd0);
    check("cnt after reset", 64'(ifa.busy_cnt), 64'd0);

    // 4 ports, 64 bit, no forwarding
    tick(); idle_b();
    ifb.we0 = 1'b1; ifb.wa0 = 5'd10; ifb.wd0 = 64'hCAFEBABE_01234567;
    ifb.ra = {5'd10, 5'd0, 5'd3, 5'd10};
    #1 check("b no fwd", ifb.rd[63:0], 64'd0);
    tick(); idle_b();
    ifb.ra = {5'd10, 5'd0, 5'd3, 5'd10};
    #1 check("b stored p0", ifb.rd[63:0], 64'hCAFEBABE_01234567);
    check("b stored p3", ifb.rd[192 +: 64], 64'hCAFEBABE_01234567);
    check("b x0 p2", ifb.rd[128 +: 64], 64'd0);
    tick(); idle_b();
    ifb.res_en = 1'b1; ifb.res_addr = 5'd12;
    tick(); idle_b();
    ifb.we1 = 1'b1; ifb.wa1 = 5'd12; ifb.wd1 = 64'h0123_4567_89AB_CDEF;
    ifb.ra = {5'd12, 5'd0, 5'd0, 5'd12};
    #1 check("b busy kept", 64'(ifb.rbusy), 64'b1001);
    check("b old data", ifb.rd[63:0], 64'd0);
    check("b cnt", 64'(ifb.busy_cnt), 64'd1);
    tick(); idle_b();
    ifb.ra = {5'd12, 5'd0, 5'd0, 5'd12};
    #1 check("b busy cleared", 64'(ifb.rbusy), 64'd0);
    check("b new data", ifb.rd[63:0], 64'h0123_4567_89AB_CDEF);
    check("b cnt cleared", 64'(ifb.busy_cnt), 64'd0);

    tick();
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
